// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit limits and helpers
// used by the multi-digit counter and its per-decade slices.
package bcd_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_MIN    = 4'd0;
  localparam int         MAX_DIGITS = 8;

  function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // All-9s packed vector for the lowest `digits` decades; upper decades stay 0.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] all_nines(input int digits);
    logic [BCD_W*MAX_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) v[i*BCD_W +: BCD_W] = BCD_MAX;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: sync reset, sanitising load, up/down step with carry/borrow out.
// Latency 1 clock for load/step; en_out is combinational from en_in, up and q_digit.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] rst_val,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             en_in,
  input  logic             up,
  input  logic             freeze,
  output logic [BCD_W-1:0] q_digit,
  output logic             en_out
);

  logic at_edge;

  assign at_edge = up ? (q_digit == BCD_MAX) : (q_digit == BCD_MIN);
  assign en_out  = en_in & at_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_digit <= rst_val;
    end else if (load) begin
      // Non-decimal nibbles are forced to 0 so q is always valid BCD.
      q_digit <= is_bcd(ld_val) ? ld_val : BCD_MIN;
    end else if (en_in && !freeze) begin
      if (up) q_digit <= at_edge ? BCD_MIN : q_digit + 4'd1;
      else    q_digit <= at_edge ? BCD_MAX : q_digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_multi.sv
// DIGITS-decade BCD up/down counter with load, enable and terminal count; 1-clock latency.
// Wraps at the boundary by default; defining BCD_SAT_EN makes it saturate instead.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int                    DIGITS  = 4,
  parameter logic [4*DIGITS-1:0]   RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                load_err
);

  logic [DIGITS:0] carry;
  logic            freeze;
  logic            din_bad;

  assign carry[0] = en;
  assign tc       = carry[DIGITS];

`ifdef BCD_SAT_EN
  // At the boundary the whole count is blocked, leaving tc asserted.
  assign freeze = tc;
`else
  assign freeze = 1'b0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i*BCD_W +: BCD_W]),
      .load    (load),
      .ld_val  (din[i*BCD_W +: BCD_W]),
      .en_in   (carry[i]),
      .up      (up),
      .freeze  (freeze),
      .q_digit (q[i*BCD_W +: BCD_W]),
      .en_out  (carry[i+1])
    );
  end

  always_comb begin
    din_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(din[i*BCD_W +: BCD_W])) din_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       load_err <= 1'b0;
    else if (load) load_err <= din_bad;
    else           load_err <= 1'b0;
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi (DIGITS=4): directed scenarios plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_bcd_counter_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] din;
  logic [15:0] q;
  logic        tc;
  logic        load_err;

  int vectors;
  int errors;

  int m_val;
  bit m_err;

  bcd_counter_multi #(.DIGITS(4), .RST_VAL(16'h0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .tc       (tc),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal value of a load word, with non-decimal digits taken as 0.
  function automatic int load_value(input logic [15:0] w);
    int v;
    int scale;
    int d;
    v = 0;
    scale = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(w[i*4 +: 4]);
      if (d > 9) d = 0;
      v = v + d * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  function automatic bit load_bad(input logic [15:0] w);
    bit b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) if (int'(w[i*4 +: 4]) > 9) b = 1'b1;
    return b;
  endfunction

  function automatic bit exp_tc();
    return en && (up ? (m_val == 9999) : (m_val == 0));
  endfunction

  // Advance one clock edge and move the model with it.
  task automatic tick();
    int nv;
    bit ne;
    nv = m_val;
    ne = 1'b0;
    if (rst) begin
      nv = 0;
    end else if (load) begin
      nv = load_value(din);
      ne = load_bad(din);
    end else if (en) begin
`ifdef BCD_SAT_EN
      if (up) nv = (m_val == 9999) ? 9999 : m_val + 1;
      else    nv = (m_val == 0) ? 0 : m_val - 1;
`else
      if (up) nv = (m_val + 1) % 10000;
      else    nv = (m_val + 9999) % 10000;
`endif
    end
    @(posedge clk);
    #1;
    m_val = nv;
    m_err = ne;
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input bit u, input logic [15:0] d);
    rst = r; load = l; en = e; up = u; din = d;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 16'h0000);
    tick();
    vectors++;
    if (q !== 16'h0000) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 16'h0000); end
    vectors++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    drive(0, 0, 1, 1, 16'h0000);
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (q !== 16'h0010) begin errors++; $display("FAIL count10 got=%h exp=%h", q, 16'h0010); end
  endtask

  task automatic test_load_carry();
    drive(0, 1, 0, 1, 16'h0999);
    tick();
    drive(0, 0, 1, 1, 16'h0000);
    tick();
    vectors++;
    if (q !== 16'h1000) begin errors++; $display("FAIL carry_ripple got=%h exp=%h", q, 16'h1000); end
    drive(0, 1, 1, 1, 16'h0042);
    tick();
    vectors++;
    if (q !== 16'h0042) begin errors++; $display("FAIL load_over_en got=%h exp=%h", q, 16'h0042); end
  endtask

  task automatic test_wrap_up();
    logic [15:0] exp_q;
    drive(0, 1, 0, 1, 16'h9999);
    tick();
    drive(0, 0, 1, 1, 16'h0000);
    vectors++;
    if (tc !== 1'b1) begin errors++; $display("FAIL tc_up_pre got=%b exp=1", tc); end
    tick();
`ifdef BCD_SAT_EN
    exp_q = 16'h9999;
`else
    exp_q = 16'h0000;
`endif
    vectors++;
    if (q !== exp_q) begin errors++; $display("FAIL wrap_up got=%h exp=%h", q, exp_q); end
    vectors++;
    if (tc !== exp_tc()) begin errors++; $display("FAIL tc_up_post got=%b exp=%b", tc, exp_tc()); end
    drive(0, 0, 1, 0, 16'h0000);
    vectors++;
    if (tc !== exp_tc()) begin errors++; $display("FAIL tc_dir_change got=%b exp=%b", tc, exp_tc()); end
  endtask

  task automatic test_wrap_down();
    logic [15:0] exp_q;
    drive(0, 1, 0, 0, 16'h0000);
    tick();
    drive(0, 0, 1, 0, 16'h0000);
    vectors++;
    if (tc !== 1'b1) begin errors++; $display("FAIL tc_down_pre got=%b exp=1", tc); end
    tick();
`ifdef BCD_SAT_EN
    exp_q = 16'h0000;
`else
    exp_q = 16'h9999;
`endif
    vectors++;
    if (q !== exp_q) begin errors++; $display("FAIL wrap_down got=%h exp=%h", q, exp_q); end
    drive(0, 1, 0, 0, 16'h1000);
    tick();
    drive(0, 0, 1, 0, 16'h0000);
    vectors++;
    if (tc !== 1'b0) begin errors++; $display("FAIL tc_down_mid got=%b exp=0", tc); end
    tick();
    vectors++;
    if (q !== 16'h0999) begin errors++; $display("FAIL borrow_ripple got=%h exp=%h", q, 16'h0999); end
  endtask

  task automatic test_load_err();
    drive(0, 1, 0, 0, 16'h12A4);
    tick();
    vectors++;
    if (q !== 16'h1204) begin errors++; $display("FAIL sanitise got=%h exp=%h", q, 16'h1204); end
    vectors++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL load_err_set got=%b exp=1", load_err); end
    drive(0, 0, 0, 0, 16'h0000);
    tick();
    vectors++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_clear got=%b exp=0", load_err); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    words[0] = 16'hFFFF; words[1] = 16'h5B3C; words[2] = 16'h8765; words[3] = 16'h9E09;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, i[0], 1, words[i]);
      tick();
      vectors++;
      if (q !== int2bcd(m_val)) begin errors++; $display("FAIL b2b_q[%0d] got=%h exp=%h", i, q, int2bcd(m_val)); end
      vectors++;
      if (load_err !== m_err) begin errors++; $display("FAIL b2b_err[%0d] got=%b exp=%b", i, load_err, m_err); end
    end
  endtask

  task automatic test_rst_priority();
    drive(0, 1, 0, 1, 16'h0357);
    tick();
    drive(1, 1, 1, 1, 16'hA123);
    tick();
    vectors++;
    if (q !== 16'h0000) begin errors++; $display("FAIL rst_over_load got=%h exp=%h", q, 16'h0000); end
    vectors++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL rst_load_err got=%b exp=0", load_err); end
    drive(0, 1, 0, 1, 16'h0357);
    tick();
    drive(0, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (q !== 16'h0357) begin errors++; $display("FAIL hold[%0d] got=%h exp=%h", i, q, 16'h0357); end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        // Bias digits towards 9/0 so boundaries and illegal nibbles both appear.
        case ($urandom_range(0, 5))
          0:       d[i*4 +: 4] = 4'd9;
          1:       d[i*4 +: 4] = 4'd0;
          2:       d[i*4 +: 4] = 4'($urandom_range(10, 15));
          default: d[i*4 +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), d);
      vectors++;
      if (tc !== exp_tc()) begin errors++; $display("FAIL rand_tc[%0d] got=%b exp=%b", n, tc, exp_tc()); end
      tick();
      vectors++;
      if (q !== int2bcd(m_val)) begin errors++; $display("FAIL rand_q[%0d] got=%h exp=%h", n, q, int2bcd(m_val)); end
      vectors++;
      if (load_err !== m_err) begin errors++; $display("FAIL rand_err[%0d] got=%b exp=%b", n, load_err, m_err); end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    m_val   = 0;
    m_err   = 1'b0;
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; din = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_carry();
    test_wrap_up();
    test_wrap_down();
    test_load_err();
    test_back_to_back();
    test_rst_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
